// File: rtl/note_voice_allocator.sv
// note_voice_allocator
// Turns the camera's per-frame 12-key pressed vector into three 4-bit note codes
// (0 = silent, 1..12 = C4..B4). Each key is debounced over consecutive accepted frames,
// then held keys are assigned to free voice slots; a voice keeps its note until its key
// is released. Outputs update together once per accepted frame.
//
// Optional feature macro: NOTE_ALLOC_STEAL_EN
//   defined   - when no voice is free, the oldest voice is stolen for the new key
//   undefined - the key waits for a later frame; no age tracking is built
//
// state     | meaning
// IDLE      | waiting for keys_valid_in; captures the raw frame
// DEBOUNCE  | update per-key counters and debounced state
// RELEASE   | free every voice whose key is no longer pressed
// SCAN      | one key per cycle (k = 0..11), assign new keys to voices
// COMMIT    | copy working voices to the outputs in one step
module note_voice_allocator #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] keys_in,
    input  logic        keys_valid_in,
    output logic [3:0]  note_1_out,
    output logic [3:0]  note_2_out,
    output logic [3:0]  note_3_out,
    output logic [1:0]  active_voices_out,
    output logic        busy_out,
    output logic        frame_drop_out
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0] LAST_KEY = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_RELEASE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  scan_k_q, scan_k_d;
    logic [11:0] raw_q, raw_d;
    logic [11:0] deb_q, deb_d;
    logic [3:0]  cnt_q   [12];
    logic [3:0]  cnt_d   [12];
    logic [3:0]  voice_q [3];
    logic [3:0]  voice_d [3];
    logic [3:0]  note_q  [3];
    logic [3:0]  note_d  [3];
    logic [1:0]  active_q, active_d;
    logic        frame_drop_q, frame_drop_d;

    logic [3:0]  scan_code;
    logic        scan_held;
    logic        free_found;
    logic [1:0]  free_idx;
    logic [2:0]  keep;

`ifdef NOTE_ALLOC_STEAL_EN
    // Age rank among busy voices: 0 = newest. Kept compact (0..n-1) so the
    // oldest voice is always rank 2 when all three are busy.
    logic [1:0]  age_q [3];
    logic [1:0]  age_d [3];
    logic [1:0]  oldest_idx;
`endif

    // Lookups on the working voices: key held, lowest free voice, voices still pressed.
    always_comb begin
        scan_code  = scan_k_q + 4'd1;
        scan_held  = 1'b0;
        free_found = 1'b0;
        free_idx   = 2'd0;
        keep       = '0;
        for (int v = 2; v >= 0; v--) begin
            if (voice_q[v] == scan_code) begin
                scan_held = 1'b1;
            end
            if (voice_q[v] == 4'd0) begin
                free_found = 1'b1;
                free_idx   = 2'(v);
            end
            for (int k = 0; k < 12; k++) begin
                if ((voice_q[v] == 4'(k + 1)) && deb_q[k]) begin
                    keep[v] = 1'b1;
                end
            end
        end
`ifdef NOTE_ALLOC_STEAL_EN
        oldest_idx = 2'd0;
        for (int v = 0; v < 3; v++) begin
            if (age_q[v] == 2'd2) begin
                oldest_idx = 2'(v);
            end
        end
`endif
    end

    // Next-state and datapath updates for the frame-processing sequence.
    always_comb begin
        state_d      = state_q;
        scan_k_d     = scan_k_q;
        raw_d        = raw_q;
        deb_d        = deb_q;
        cnt_d        = cnt_q;
        voice_d      = voice_q;
        note_d       = note_q;
        active_d     = active_q;
`ifdef NOTE_ALLOC_STEAL_EN
        age_d        = age_q;
`endif
        // A strobe outside IDLE is ignored and flagged on the following cycle.
        frame_drop_d = keys_valid_in && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (keys_valid_in) begin
                    raw_d   = keys_in;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                for (int k = 0; k < 12; k++) begin
                    if (raw_q[k] == deb_q[k]) begin
                        cnt_d[k] = 4'd0;
                    end else if ((cnt_q[k] + 4'd1) == DB_LIMIT) begin
                        deb_d[k] = ~deb_q[k];
                        cnt_d[k] = 4'd0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 4'd1;
                    end
                end
                state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                for (int v = 0; v < 3; v++) begin
                    if (!keep[v]) begin
                        voice_d[v] = 4'd0;
                    end
                end
`ifdef NOTE_ALLOC_STEAL_EN
                // Re-rank survivors so ranks stay contiguous from 0.
                for (int v = 0; v < 3; v++) begin
                    age_d[v] = 2'd0;
                    if (keep[v]) begin
                        for (int u = 0; u < 3; u++) begin
                            if (keep[u] && (age_q[u] < age_q[v])) begin
                                age_d[v] = age_d[v] + 2'd1;
                            end
                        end
                    end
                end
`endif
                scan_k_d = 4'd0;
                state_d  = ST_SCAN;
            end

            ST_SCAN: begin
                if (deb_q[scan_k_q] && !scan_held) begin
                    if (free_found) begin
                        voice_d[free_idx] = scan_code;
`ifdef NOTE_ALLOC_STEAL_EN
                        for (int v = 0; v < 3; v++) begin
                            if (2'(v) == free_idx) begin
                                age_d[v] = 2'd0;
                            end else if (voice_q[v] != 4'd0) begin
                                age_d[v] = age_q[v] + 2'd1;
                            end
                        end
`endif
                    end
`ifdef NOTE_ALLOC_STEAL_EN
                    else begin
                        voice_d[oldest_idx] = scan_code;
                        for (int v = 0; v < 3; v++) begin
                            if (2'(v) == oldest_idx) begin
                                age_d[v] = 2'd0;
                            end else begin
                                age_d[v] = age_q[v] + 2'd1;
                            end
                        end
                    end
`endif
                end
                if (scan_k_q == LAST_KEY) begin
                    state_d = ST_COMMIT;
                end else begin
                    scan_k_d = scan_k_q + 4'd1;
                end
            end

            ST_COMMIT: begin
                note_d   = voice_q;
                active_d = {1'b0, voice_q[0] != 4'd0}
                         + {1'b0, voice_q[1] != 4'd0}
                         + {1'b0, voice_q[2] != 4'd0};
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All registers; reset returns every one of them to power-up values at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            scan_k_q     <= 4'd0;
            raw_q        <= 12'd0;
            deb_q        <= 12'd0;
            active_q     <= 2'd0;
            frame_drop_q <= 1'b0;
            for (int k = 0; k < 12; k++) begin
                cnt_q[k] <= 4'd0;
            end
            for (int v = 0; v < 3; v++) begin
                voice_q[v] <= 4'd0;
                note_q[v]  <= 4'd0;
`ifdef NOTE_ALLOC_STEAL_EN
                age_q[v]   <= 2'd0;
`endif
            end
        end else begin
            state_q      <= state_d;
            scan_k_q     <= scan_k_d;
            raw_q        <= raw_d;
            deb_q        <= deb_d;
            active_q     <= active_d;
            frame_drop_q <= frame_drop_d;
            for (int k = 0; k < 12; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            for (int v = 0; v < 3; v++) begin
                voice_q[v] <= voice_d[v];
                note_q[v]  <= note_d[v];
`ifdef NOTE_ALLOC_STEAL_EN
                age_q[v]   <= age_d[v];
`endif
            end
        end
    end

    assign note_1_out        = note_q[0];
    assign note_2_out        = note_q[1];
    assign note_3_out        = note_q[2];
    assign active_voices_out = active_q;
    assign busy_out          = (state_q != ST_IDLE);
    assign frame_drop_out    = frame_drop_q;

endmodule

// File: tb/tb_note_voice_allocator.sv
// Testbench for note_voice_allocator: directed scenarios plus randomized frames
// checked against a queue-based reference model of debounce and voice allocation.
module tb_note_voice_allocator;

    localparam int DB = 3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [11:0] keys_in = 12'd0;
    logic        keys_valid_in = 1'b0;
    logic [3:0]  note_1_out, note_2_out, note_3_out;
    logic [1:0]  active_voices_out;
    logic        busy_out, frame_drop_out;

    int total = 0;
    int bad   = 0;

    // Reference model: per-key counters and debounced state, voice contents,
    // and an age order of busy voices (front = newest, back = oldest).
    int m_cnt [12];
    bit m_deb [12];
    int m_voice [3];
    int m_order [$];

    logic [13:0] snap14, snap15;
    logic        snap14_busy, snap15_busy;

    note_voice_allocator #(.DEBOUNCE_FRAMES(DB)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .keys_in           (keys_in),
        .keys_valid_in     (keys_valid_in),
        .note_1_out        (note_1_out),
        .note_2_out        (note_2_out),
        .note_3_out        (note_3_out),
        .active_voices_out (active_voices_out),
        .busy_out          (busy_out),
        .frame_drop_out    (frame_drop_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [13:0] dut_vec();
        return {note_1_out, note_2_out, note_3_out, active_voices_out};
    endfunction

    function automatic logic [13:0] model_vec();
        int n = 0;
        for (int v = 0; v < 3; v++) if (m_voice[v] != 0) n++;
        return {4'(m_voice[0]), 4'(m_voice[1]), 4'(m_voice[2]), 2'(n)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) begin
            m_cnt[i] = 0;
            m_deb[i] = 1'b0;
        end
        for (int v = 0; v < 3; v++) m_voice[v] = 0;
        m_order.delete();
    endfunction

    function automatic void order_remove(input int v);
        for (int i = 0; i < m_order.size(); i++) begin
            if (m_order[i] == v) begin
                m_order.delete(i);
                break;
            end
        end
    endfunction

    function automatic void model_frame(input logic [11:0] k);
        int  free_v;
        bit  held;
        for (int i = 0; i < 12; i++) begin
            if (k[i] == m_deb[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == DB) begin
                    m_deb[i] = !m_deb[i];
                    m_cnt[i] = 0;
                end
            end
        end
        for (int v = 0; v < 3; v++) begin
            if (m_voice[v] != 0 && !m_deb[m_voice[v] - 1]) begin
                m_voice[v] = 0;
                order_remove(v);
            end
        end
        for (int key = 1; key <= 12; key++) begin
            if (!m_deb[key - 1]) continue;
            held = 1'b0;
            for (int v = 0; v < 3; v++) if (m_voice[v] == key) held = 1'b1;
            if (held) continue;
            free_v = -1;
            for (int v = 2; v >= 0; v--) if (m_voice[v] == 0) free_v = v;
            if (free_v >= 0) begin
                m_voice[free_v] = key;
                m_order.push_front(free_v);
            end
`ifdef NOTE_ALLOC_STEAL_EN
            else begin
                free_v = m_order.pop_back();
                m_voice[free_v] = key;
                m_order.push_front(free_v);
            end
`endif
        end
    endfunction

    // One accepted frame: strobe at edge 0, snapshots after edges 14 and 15,
    // then idle until the next strobe slot `gap` cycles later. keys_in carries
    // noise between strobes, which must have no effect.
    task automatic do_frame(input logic [11:0] k, input int gap);
        @(negedge clk_in);
        keys_in       = k;
        keys_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        keys_valid_in = 1'b0;
        keys_in       = 12'($urandom_range(0, 4095));
        model_frame(k);
        repeat (14) @(posedge clk_in);
        #1;
        snap14      = dut_vec();
        snap14_busy = busy_out;
        @(posedge clk_in);
        #1;
        snap15      = dut_vec();
        snap15_busy = busy_out;
        repeat (gap - 16) @(posedge clk_in);
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #3;
        rst_in = 1'b1;
        #1;
        total++;
        if ({dut_vec(), busy_out, frame_drop_out} !== 16'd0) begin
            bad++;
            $display("FAIL reset_async got=%h want=0", {dut_vec(), busy_out, frame_drop_out});
        end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic test_debounce();
        logic [13:0] want;
        apply_reset();
        do_frame(12'h001, 20);
        do_frame(12'h001, 20);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL deb_two_frames got=%h want=0", dut_vec());
        end
        do_frame(12'h001, 20);
        want = {4'd1, 4'd0, 4'd0, 2'd1};
        total++;
        if (snap14 !== 14'd0) begin
            bad++;
            $display("FAIL lat_edge14 got=%h want=0", snap14);
        end
        total++;
        if (snap14_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_edge14 got=%b want=1", snap14_busy);
        end
        total++;
        if (snap15 !== want) begin
            bad++;
            $display("FAIL lat_edge15 got=%h want=%h", snap15, want);
        end
        total++;
        if (snap15_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_edge15 got=%b want=0", snap15_busy);
        end
        repeat (3) do_frame(12'h000, 20);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL deb_release got=%h want=0", dut_vec());
        end
        do_frame(12'h001, 20);
        do_frame(12'h001, 20);
        repeat (3) do_frame(12'h000, 20);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL deb_glitch got=%h want=0", dut_vec());
        end
    endtask

    task automatic test_release_reuse();
        logic [13:0] want;
        apply_reset();
        repeat (3) do_frame(12'h011, 20);
        want = {4'd1, 4'd5, 4'd0, 2'd2};
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL reuse_hold got=%h want=%h", dut_vec(), want);
        end
        repeat (2) do_frame(12'h010, 20);
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL reuse_early_release got=%h want=%h", dut_vec(), want);
        end
        do_frame(12'h010, 20);
        want = {4'd0, 4'd5, 4'd0, 2'd1};
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL reuse_release got=%h want=%h", dut_vec(), want);
        end
        repeat (3) do_frame(12'h090, 20);
        want = {4'd8, 4'd5, 4'd0, 2'd2};
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL reuse_refill got=%h want=%h", dut_vec(), want);
        end
    endtask

    task automatic test_overflow();
        logic [13:0] want;
        apply_reset();
        repeat (3) do_frame(12'h00F, 20);
`ifdef NOTE_ALLOC_STEAL_EN
        want = {4'd4, 4'd2, 4'd3, 2'd3};
`else
        want = {4'd1, 4'd2, 4'd3, 2'd3};
`endif
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL overflow got=%h want=%h", dut_vec(), want);
        end
        for (int i = 0; i < 2; i++) begin
            do_frame(12'h00F, 20);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL overflow_hold%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
        repeat (3) do_frame(12'h00E, 20);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL overflow_retry got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_overrun();
        logic [13:0] want;
        apply_reset();
        repeat (2) do_frame(12'h001, 20);
        @(negedge clk_in);
        keys_in       = 12'h001;
        keys_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        keys_valid_in = 1'b0;
        model_frame(12'h001);
        repeat (4) @(posedge clk_in);
        #1;
        total++;
        if (frame_drop_out !== 1'b0) begin
            bad++;
            $display("FAIL drop_before got=%b want=0", frame_drop_out);
        end
        @(negedge clk_in);
        keys_in       = 12'hFFF;
        keys_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        keys_valid_in = 1'b0;
        total++;
        if (frame_drop_out !== 1'b1) begin
            bad++;
            $display("FAIL drop_pulse got=%b want=1", frame_drop_out);
        end
        @(posedge clk_in);
        #1;
        total++;
        if (frame_drop_out !== 1'b0) begin
            bad++;
            $display("FAIL drop_width got=%b want=0", frame_drop_out);
        end
        repeat (9) @(posedge clk_in);
        #1;
        want = {4'd1, 4'd0, 4'd0, 2'd1};
        total++;
        if ({dut_vec(), busy_out} !== {want, 1'b0}) begin
            bad++;
            $display("FAIL overrun_result got=%h want=%h", {dut_vec(), busy_out}, {want, 1'b0});
        end
        repeat (4) @(posedge clk_in);
        do_frame(12'h001, 20);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL overrun_after got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [13:0] want;
        apply_reset();
        repeat (3) do_frame(12'h007, 20);
        want = {4'd1, 4'd2, 4'd3, 2'd3};
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL three_voices got=%h want=%h", dut_vec(), want);
        end
        @(negedge clk_in);
        keys_in       = 12'h007;
        keys_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        keys_valid_in = 1'b0;
        repeat (6) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        total++;
        if ({dut_vec(), busy_out, frame_drop_out} !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_scan got=%h want=0", {dut_vec(), busy_out, frame_drop_out});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        repeat (5) @(posedge clk_in);
        do_frame(12'h007, 20);
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL post_reset_first got=%h want=0", dut_vec());
        end
        repeat (2) do_frame(12'h007, 20);
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL post_reset_third got=%h want=%h", dut_vec(), want);
        end
    endtask

    task automatic test_random();
        logic [11:0] pat;
        logic [11:0] k;
        apply_reset();
        pat = 12'd0;
        for (int i = 0; i < 48; i++) begin
            if ((i % 4) == 0) begin
                pat = 12'($urandom) & 12'($urandom) & 12'($urandom);
            end
            k = pat;
            if ($urandom_range(0, 3) == 0) begin
                k = k ^ (12'd1 << $urandom_range(0, 11));
            end
            do_frame(k, 16 + int'($urandom_range(0, 8)));
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random_frame%0d keys=%h got=%h want=%h", i, k, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_release_reuse();
        test_overflow();
        test_overrun();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
